inst_mem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch stage's request/we_re/mask/address interface.
- Accepts one request per cycle and returns the addressed word after a fixed, parameterised latency, with a valid strobe.
- Supports masked byte writes for program loading.
- Sits between the fetch stage and the instruction SRAM model.
- Handles flush on redirect (branch/jal/jalr) so that stale responses are never delivered.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_resp_pipe.sv | 37 +++
 rtl/inst_mem_responder.sv | 77 +++++++
 tb/tb_inst_mem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Response bundle carried through the read-latency pipeline.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int MAX_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_resp_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// LATENCY-deep shift of read responses.
// Flush kills everything already in flight; the new entry survives.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  imem_resp_t in_resp,
  output imem_resp_t out_resp
);

  imem_resp_t stage [LATENCY];

  // Shift responses one stage per edge; flush clears in-flight valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '{valid: 1'b0, err: 1'b0, data: NOP_INSTR};
      end
    end else begin
      stage[0] <= in_resp;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= '{
          valid: stage[i-1].valid & ~flush,
          err:   stage[i-1].err,
          data:  stage[i-1].data
        };
      end
    end
  end

  assign out_resp = stage[LATENCY-1];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory with fixed-latency read responses and masked writes.
// Memory initialises to NOP at time zero.
module inst_mem_responder
  import imem_pkg::*;
#(
  parameter int INSTRUCTION = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request,
  input  logic                   we_re,
  input  logic [3:0]             mask,
  input  logic [ADDRESS-1:0]     address,
  input  logic [INSTRUCTION-1:0] wdata,
  input  logic                   flush,
  output logic [INSTRUCTION-1:0] instruction_fetch,
  output logic                   valid,
  output logic                   addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [INSTRUCTION-1:0] mem [DEPTH];
  logic [IDX_W-1:0]       idx;
  logic                   misaligned;
  logic                   out_of_range;
  logic                   bad;
  logic [INSTRUCTION-1:0] held;
  imem_resp_t             pipe_in;
  imem_resp_t             pipe_out;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_INSTR;
  end

  assign idx          = address[IDX_W+1:2];
  assign misaligned   = |address[1:0];
  assign out_of_range = |(address >> (IDX_W + 2));
  assign bad          = misaligned | out_of_range;

  always_ff @(posedge clk) begin
    if (!rst && request && we_re && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign pipe_in = '{
    valid: request & ~we_re,
    err:   bad,
    data:  bad ? NOP_INSTR : mem[idx]
  };

  imem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_resp  (pipe_in),
    .out_resp (pipe_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) held <= NOP_INSTR;
    else if (pipe_out.valid) held <= pipe_out.data;
  end

  assign valid             = pipe_out.valid;
  assign addr_err          = pipe_out.valid & pipe_out.err;
  assign instruction_fetch = pipe_out.valid ? pipe_out.data : held;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized and directed checks of inst_mem_responder.
// Reference model: word array plus a queue of scheduled responses.
module tb_inst_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        request = 1'b0;
  logic        we_re = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] instruction_fetch;
  logic        valid;
  logic        addr_err;

  always #5 clk = ~clk;

  inst_mem_responder #(
    .INSTRUCTION (32),
    .ADDRESS     (32),
    .DEPTH       (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .request           (request),
    .we_re             (we_re),
    .mask              (mask),
    .address           (address),
    .wdata             (wdata),
    .flush             (flush),
    .instruction_fetch (instruction_fetch),
    .valid             (valid),
    .addr_err          (addr_err)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [DEPTH];
  logic [31:0] hold;
  logic        ev, ee;
  logic [31:0] ed;
  int          edge_n;
  int          vec;
  int          errs;

  // One clock of stimulus; updates model and leaves expectations in ev/ee/ed
  task automatic step(input logic r, input logic w, input logic [3:0] m,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic f);
    logic bad;
    int   idx;
    @(negedge clk);
    request = r; we_re = w; mask = m; address = a; wdata = d; flush = f;
    @(posedge clk);
    edge_n++;
    bad = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    idx = int'((a / 4) % DEPTH);
    if (f) q.delete();
    if (r && !w) q.push_back('{edge_n + LAT - 1, bad ? NOP : mm[idx], bad});
    if (r && w && !bad) begin
      for (int b = 0; b < 4; b++) if (m[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
    end
    ev = 1'b0;
    ee = 1'b0;
    if (q.size() != 0 && q[0].due == edge_n) begin
      ev = 1'b1;
      ee = q[0].err;
      hold = q[0].data;
      void'(q.pop_front());
    end
    ed = hold;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    vec++;
    if (valid !== 1'b0 || addr_err !== 1'b0 || instruction_fetch !== NOP) begin
      errs++;
      $display("FAIL reset: got v=%b e=%b d=%h want v=0 e=0 d=%h",
               valid, addr_err, instruction_fetch, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_after_reset();
    step(1, 1, 4'hF, 32'h0C, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    request = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    q.delete();
    hold = NOP;
    for (int i = 0; i < LAT + 1; i++) begin
      step(i == 0, 0, 4'h0, 32'h0C, 32'h0, 0);
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL read_after_reset c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
      if (i == LAT - 1) begin
        vec++;
        if (valid !== 1'b1 || instruction_fetch !== 32'hDEAD_BEEF) begin
          errs++;
          $display("FAIL read_deadbeef: got v=%b d=%h want v=1 d=deadbeef",
                   valid, instruction_fetch);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1, 1, 4'hF, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 4 + LAT; i++) begin
      step(i < 4, 0, 4'h0, 32'(i * 4), 32'h0, 0);
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL back_to_back c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
    end
  endtask

  task automatic test_masked_write();
    step(1, 1, 4'hF, 32'h10, 32'hAAAA_AAAA, 0);
    step(1, 1, 4'b0101, 32'h10, 32'h1122_3344, 0);
    for (int i = 0; i < LAT + 1; i++) begin
      step(i == 0, 0, 4'h0, 32'h10, 32'h0, 0);
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL masked_write c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
      if (i == LAT - 1) begin
        vec++;
        if (valid !== 1'b1 || instruction_fetch !== 32'hAA22_AA44) begin
          errs++;
          $display("FAIL masked_word: got v=%b d=%h want v=1 d=aa22aa44",
                   valid, instruction_fetch);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6];
    logic        ws [6];
    addrs = '{32'h6, 32'(DEPTH * 4), 32'h6, 32'h4, 32'h0, 32'h0};
    ws    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 4) step(1, ws[i], 4'hF, addrs[i], 32'h5555_0000, 0);
      else step(0, 0, 4'h0, 32'h0, 32'h0, 0);
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL errors c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
    end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3 + LAT + 1; i++) begin
      step(i < 3, 0, 4'h0, 32'(i * 4), 32'h0, i == 2);
      if (valid === 1'b1) pulses++;
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL flush c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
    end
    vec++;
    if (pulses !== 1) begin
      errs++;
      $display("FAIL flush_pulses: got %0d want 1", pulses);
    end
    step(0, 0, 4'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 32'(i * 4), 32'h0, 0);
    vec++;
    if (valid !== ev || instruction_fetch !== ed) begin
      errs++;
      $display("FAIL pre_reset: got v=%b d=%h want v=%b d=%h",
               valid, instruction_fetch, ev, ed);
    end
    #2 rst = 1'b1;
    #1;
    q.delete();
    hold = NOP;
    vec++;
    if (valid !== 1'b0 || addr_err !== 1'b0 || instruction_fetch !== NOP) begin
      errs++;
      $display("FAIL mid_reset: got v=%b e=%b d=%h want v=0 e=0 d=%h",
               valid, addr_err, instruction_fetch, NOP);
    end
    request = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * LAT + 2; i++) begin
      step(i == LAT + 1, 0, 4'h0, 32'h8, 32'h0, 0);
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL after_reset c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
    end
  endtask

  task automatic test_random();
    logic        r, w, f;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 400 + LAT; i++) begin
      k = int'($urandom_range(0, 19));
      if (k == 0) a = $urandom;
      else if (k == 1) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else a = 32'($urandom_range(0, 15) * 4);
      r = (i < 400) && ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 3) == 0);
      f = (i < 400) && ($urandom_range(0, 15) == 0);
      step(r, w, 4'($urandom), a, $urandom, f);
      vec++;
      if (valid !== ev || addr_err !== ee || instruction_fetch !== ed) begin
        errs++;
        $display("FAIL random c%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 i, valid, addr_err, instruction_fetch, ev, ee, ed);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
    hold   = NOP;
    edge_n = 0;
    vec    = 0;
    errs   = 0;
    test_reset();
    test_read_after_reset();
    test_back_to_back();
    test_masked_write();
    test_errors();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
